bus_source_sequencer: RTL and testbench

- Drive side of the shared 32-bit datapath bus: queues register-transfer requests and generates the one-hot source-enable strobes (R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout) that select the bus mux input.
- Generates the matching one-hot destination-load strobe, so exactly one source drives the bus in any cycle and exactly one destination captures it.
- Sits between the control unit and the bus/register file; replaces hand-sequenced out/in strobes.

---
 rtl/bus_source_sequencer.sv | 119 +++++++++++
 tb/tb_bus_source_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_source_sequencer.sv
// Bus source/destination sequencer: queues register-transfer requests and drives
// one-hot source-enable and destination-load strobes with a one-cycle bus turnaround.
module bus_source_sequencer #(
  parameter int NUM_SRC    = 23,
  parameter int NUM_DST    = 23,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [4:0]         req_src,
  input  logic [4:0]         req_dst,
  input  logic [1:0]         req_hold,
  output logic [NUM_SRC-1:0] src_out,
  output logic [NUM_DST-1:0] dst_in,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [NUM_SRC-1:0] SRC_ONE = NUM_SRC'(1);
  localparam logic [NUM_DST-1:0] DST_ONE = NUM_DST'(1);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} stateType;

  typedef struct packed {
    logic [4:0] src;
    logic [4:0] dst;
    logic [1:0] hold;
  } xferType;

  stateType      state, nextState;
  xferType       fifoMem [FIFO_DEPTH];
  xferType       incoming, headXfer;
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic [4:0]    curSrc, curDst;
  logic [1:0]    beat;
  logic          accept, reqGood, push, queueEmpty, startXfer, enq, deq;

  assign incoming   = '{src: req_src, dst: req_dst, hold: req_hold};
  assign req_ready  = clear && (int'(count) < FIFO_DEPTH);
  assign accept     = req_valid && req_ready;
  assign reqGood    = (int'(req_src) < NUM_SRC) && (int'(req_dst) < NUM_DST);
  assign push       = accept && reqGood;
  assign queueEmpty = (count == '0);

  // An empty queue forwards the incoming request straight into the current
  // transfer, so an idle unit starts driving in the cycle after the accept.
  assign startXfer = (state != DRIVE) && (!queueEmpty || push);
  assign headXfer  = queueEmpty ? incoming : fifoMem[rdPtr];
  assign deq       = startXfer && !queueEmpty;
  assign enq       = push && !(startXfer && queueEmpty);

  // NOTE: every sequential assignment is non-blocking so all registers sample
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!clear) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves nextState
    // unassigned and infers a latch.
    nextState = state;
    unique case (state)
      IDLE:    if (startXfer) nextState = DRIVE;
      DRIVE:   if (beat == '0) nextState = GAP;
      GAP:     nextState = startXfer ? DRIVE : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    src_out = '0;
    dst_in  = '0;
    if (state == DRIVE) begin
      src_out = SRC_ONE << curSrc;
      if (beat == '0) dst_in = DST_ONE << curDst;
    end
    done = (state == GAP);
    busy = (state != IDLE) || !queueEmpty;
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      curSrc <= '0;
      curDst <= '0;
      beat   <= '0;
      err    <= 1'b0;
    end else begin
      err <= accept && !reqGood;
      if (enq) wrPtr <= wrPtr + PW'(1);
      if (deq) rdPtr <= rdPtr + PW'(1);
      if (enq && !deq)      count <= count + CW'(1);
      else if (deq && !enq) count <= count - CW'(1);
      if (startXfer) begin
        curSrc <= headXfer.src;
        curDst <= headXfer.dst;
        beat   <= headXfer.hold;
      end else if (state == DRIVE && beat != '0) begin
        beat <= beat - 2'd1;
      end
    end
  end

  // NOTE: queue storage carries no reset; the pointers and count alone decide
  // which entries are valid, and stale contents are never read.
  always_ff @(posedge clock) begin
    if (enq) fifoMem[wrPtr] <= incoming;
  end

endmodule

// File: tb/tb_bus_source_sequencer.sv
// Scoreboard bench for bus_source_sequencer: accepted requests are queued with
// their accept cycle and matched against observed bus-drive bursts.
module tb_bus_source_sequencer;

  localparam int NUM_SRC = 23;
  localparam int NUM_DST = 23;
  localparam int DEPTH   = 2;

  logic               clock = 1'b0;
  logic               clear = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [4:0]         req_src = '0;
  logic [4:0]         req_dst = '0;
  logic [1:0]         req_hold = '0;
  logic [NUM_SRC-1:0] src_out;
  logic [NUM_DST-1:0] dst_in;
  logic               busy, done, err;

  bus_source_sequencer #(.NUM_SRC(NUM_SRC), .NUM_DST(NUM_DST), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .req_hold(req_hold),
    .src_out(src_out), .dst_in(dst_in), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] bitOf(input int i);
    logic [31:0] one = 32'd1;
    return one << i;
  endfunction

  typedef struct {
    int src;
    int dst;
    int hold;
    int acc;
  } expType;

  expType expQ[$];
  expType cur;
  bit     inXfer = 0;
  bit     dstSeen = 0;
  bit     errNext = 0;
  bit     modelReady;
  int     runLen = 0;
  int     lastGap = -100;
  int     cyc = 0;
  int     stallCycles = 0;
  logic   lastEdgeClear = 1'b0;

  always @(posedge clock) lastEdgeClear <= clear;

  // Monitor: compare this cycle's outputs, then predict the accept at the next edge.
  always @(negedge clock) begin
    cyc++;
    if (!lastEdgeClear) begin
      check("rst_src", src_out, 0);
      expQ.delete();
      inXfer  = 0;
      errNext = 0;
      lastGap = -100;
    end
    check("err", err, errNext);
    check("src_onehot", ($countones(src_out) <= 1), 1);
    check("dst_onehot", ($countones(dst_in) <= 1), 1);
    if (src_out != '0) begin
      if (!inXfer) begin
        if (expQ.size() == 0) begin
          check("unexpected_drive", src_out, 0);
        end else begin
          cur     = expQ.pop_front();
          inXfer  = 1;
          runLen  = 0;
          dstSeen = 0;
          check("start_cycle", cyc, (cur.acc > lastGap) ? cur.acc + 1 : lastGap + 1);
        end
      end
      if (inXfer) begin
        check("src", src_out, bitOf(cur.src));
        runLen++;
        check("drive_overrun", (runLen <= cur.hold + 1), 1);
        if (dst_in != '0) begin
          check("dst", dst_in, bitOf(cur.dst));
          check("dst_cycle", runLen, cur.hold + 1);
          dstSeen = 1;
        end
      end
      check("done_in_drive", done, 0);
    end else begin
      check("dst_without_src", dst_in, 0);
      if (inXfer) begin
        check("done", done, 1);
        check("dst_seen", dstSeen, 1);
        inXfer  = 0;
        lastGap = cyc;
      end else begin
        check("done_idle", done, 0);
      end
    end
    modelReady = clear && (expQ.size() < DEPTH);
    check("ready", req_ready, modelReady);
    check("busy", busy, inXfer || (lastGap == cyc) || (expQ.size() != 0));
    errNext = 0;
    if (req_valid && modelReady) begin
      if (req_src >= NUM_SRC || req_dst >= NUM_DST) errNext = 1;
      else expQ.push_back('{src: int'(req_src), dst: int'(req_dst), hold: int'(req_hold), acc: cyc});
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input int s, input int d, input int h);
    int waited = 0;
    req_valid = 1'b1;
    req_src   = 5'(s);
    req_dst   = 5'(d);
    req_hold  = 2'(h);
    @(negedge clock);
    while (!(clear && req_ready) && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 50) check("ready_timeout", waited, 0);
    stallCycles += waited;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clock);
    while (busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("idle_timeout", n, 0);
    @(posedge clock);
    #1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    // Reset with a pending request that must not be taken.
    req_valid = 1'b1;
    req_src   = 5'd1;
    req_dst   = 5'd1;
    idleCycles(2);
    clear     = 1'b1;
    req_valid = 1'b0;
    idleCycles(2);

    send(5, 2, 0);
    waitIdle();
    send(21, 7, 3);
    waitIdle();

    send(0, 3, 0);
    send(1, 4, 0);
    send(2, 5, 0);
    waitIdle();

    stallCycles = 0;
    for (int i = 0; i < 4; i++) send(10 + i, 12 - i, 3);
    check("stall_seen", (stallCycles > 0), 1);
    waitIdle();

    send(23, 0, 0);
    send(9, 9, 1);
    send(0, 23, 2);
    send(31, 31, 0);
    waitIdle();
    send(22, 22, 2);
    waitIdle();

    // Abandon a transfer in its second drive cycle.
    send(19, 4, 3);
    idleCycles(1);
    clear = 1'b0;
    idleCycles(1);
    clear = 1'b1;
    idleCycles(3);
    send(16, 17, 1);
    waitIdle();

    for (int i = 0; i < 24; i++) begin
      send($urandom_range(0, 24), $urandom_range(0, 24), $urandom_range(0, 3));
      idleCycles($urandom_range(0, 2));
    end
    waitIdle();
    idleCycles(2);

    check("drain_queue", expQ.size(), 0);
    check("drain_xfer", inXfer, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
